regfile: RTL
============

REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers; register 0 is hardwired zero.
REQ-002 SHALL have parameter CNTW, default 2, width of the per-register pending-write counter.
REQ-003 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset, equal to `RstEnable.
REQ-005 SHALL provide port we  input  1  writeback enable, sourced from the wreg result of the execute path after the memory stage.
REQ-006 SHALL provide port waddr  input  `RegAddrBus  writeback destination register.
REQ-007 SHALL provide port wdata  input  `RegBus  writeback data.
REQ-008 SHALL provide ports re1 and re2  input  1  read enables, sourced from decode.
REQ-009 SHALL provide ports raddr1 and raddr2  input  `RegAddrBus  read addresses.
REQ-010 SHALL provide ports rdata1 and rdata2  output  `RegBus  read data feeding the reg1/reg2 operands of execute.
REQ-011 SHALL provide port iss_valid  input  1  decode is issuing an instruction that will write a register.
REQ-012 SHALL provide port iss_waddr  input  `RegAddrBus  destination of the issuing instruction.
REQ-013 SHALL provide port flush  input  1  pipeline flush; all in-flight writes are cancelled.
REQ-014 SHALL provide ports hazard1 and hazard2  output  1  the operand read on port 1 or 2 is stale.
REQ-015 SHALL provide port iss_ready  output  1  the issue is accepted this cycle.

Function
REQ-016 Storage SHALL be NREG x 32-bit, written at posedge clk when we=1, waddr!=0, and rst=0.
REQ-017 Writes to register 0 SHALL be discarded; reads of register 0 SHALL return `ZeroWord.
REQ-018 Reads SHALL be combinational; rdataN=`ZeroWord when rst=1 or reN=0.
REQ-019 Bypass: when reN=1, we=1, waddr=raddrN, and raddrN!=0, rdataN SHALL equal wdata in the same cycle.
REQ-020 Otherwise rdataN SHALL equal the stored register value.
REQ-021 Scoreboard: each register 1..NREG-1 SHALL hold a CNTW-bit unsigned pending counter cnt[r].
REQ-022 An accepted issue (iss_valid=1, iss_ready=1, iss_waddr!=0) SHALL increment cnt[iss_waddr] at posedge.
REQ-023 A writeback (we=1, waddr!=0) SHALL decrement cnt[waddr] at posedge; a decrement at 0 SHALL leave the counter at 0 with no wrap.
REQ-024 An accepted issue and a writeback to the same register in the same cycle SHALL leave that counter unchanged.
REQ-025 An accepted issue and a writeback to different registers in the same cycle SHALL both take effect.
REQ-026 iss_ready SHALL be 0 when cnt[iss_waddr] equals 2^CNTW-1 and the same-cycle writeback does not target iss_waddr; otherwise iss_ready SHALL be 1.
REQ-027 iss_ready SHALL be 1 for iss_waddr=0.
REQ-028 hazardN SHALL be 1 when reN=1, raddrN!=0, and cnt[raddrN]>0, except when cnt[raddrN]=1 and the same-cycle writeback targets raddrN, in which case the bypass makes the data valid and hazardN SHALL be 0.
REQ-029 hazardN SHALL be 0 during rst.
REQ-030 flush=1 SHALL clear all counters at posedge and SHALL ignore a same-cycle issue.
REQ-031 A same-cycle writeback under flush SHALL still update storage but not the counters.
REQ-032 Latency: a write is visible via bypass in cycle N and from storage from cycle N+1.
REQ-033 A counter update is visible on hazardN and iss_ready the cycle after the edge.

Reset
REQ-034 rst=1 at posedge SHALL clear all registers to `ZeroWord and all counters to 0, overriding we, iss_valid, and flush.
REQ-035 While rst=1: rdata1=rdata2=`ZeroWord, hazard1=hazard2=0, iss_ready=1.
REQ-036 rst asserted mid-operation SHALL discard pending counts; the first cycle after release SHALL behave as empty.

Verification
REQ-037 Write and readback: we=1, waddr=5, wdata=32'h1234_5678.
- Same cycle, re1=1, raddr1=5: rdata1=32'h1234_5678 via bypass.
- Next cycle, we=0: rdata1=32'h1234_5678 from storage.
- raddr2=0: rdata2=0.
REQ-038 Register-0 write: we=1, waddr=0, wdata=32'hFFFF_FFFF.
- Next cycle, raddr1=0: rdata1=0.
- iss_valid=1 with iss_waddr=0: all counters unchanged.
REQ-039 Scoreboard sequence:
- Issue to r7: next cycle, re1=1, raddr1=7 gives hazard1=1.
- Writeback to r7 with wdata=32'hA5 in a later cycle: hazard1=0 in that cycle, rdata1=32'hA5.
- Cycle after: cnt[7]=0.
REQ-040 Counter saturation: three issues to r3 with no writeback.
- Fourth issue: iss_ready=0, cnt[3] stays 3.
- Simultaneous issue and writeback to r3: iss_ready=1, cnt[3] stays 3.
REQ-041 Flush and reset:
- Issues to r2 and r9, then flush=1 with iss_valid=1 to r4: next cycle all hazards=0, cnt[4]=0.
- rst=1 after writing r2=32'h55: next cycle after release, rdata for r2 = 0.

Source files
------------

// File: rtl/regfile_if.sv
// regfile_if: bundles the register file's write-back, read, issue and
// scoreboard signals so decode/execute and the register file share one port.
//
// Signals (master drives, slave = regfile):
//   we, waddr, wdata      write-back port (from the memory stage)
//   re1/re2, raddr1/2     read enables and addresses (from decode)
//   rdata1/2              read data (operands for execute)
//   iss_valid, iss_waddr  decode issuing an instruction that writes iss_waddr
//   flush                 cancel every in-flight write
//   hazard1/2             operand on that read port is stale
//   iss_ready             the issue is accepted this cycle
interface regfile_if #(
  parameter int NREG = 32
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [31:0]   rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [31:0]   rdata2;
  logic          iss_valid;
  logic [AW-1:0] iss_waddr;
  logic          flush;
  logic          hazard1;
  logic          hazard2;
  logic          iss_ready;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
           iss_valid, iss_waddr, flush,
    input  rdata1, rdata2, hazard1, hazard2, iss_ready
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
           iss_valid, iss_waddr, flush,
    output rdata1, rdata2, hazard1, hazard2, iss_ready
  );
endinterface

// File: rtl/regfile.sv
// regfile: NREG x 32-bit register file with two combinational read ports,
// one write-back port with same-cycle bypass, and a per-register scoreboard
// of CNTW-bit pending-write counters that flags stale operands and throttles
// issue when a destination's counter is full. Register 0 reads as zero.
//
// Ports:
//   clk  rising-edge clock for all state
//   rst  synchronous, active-high reset (clears storage and counters)
//   bus  regfile_if.slave: write-back, read, issue, flush, hazard, ready
module regfile #(
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [31:0]     regs [NREG];
  logic [CNTW-1:0] cnt  [NREG];

  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;

  logic wb_hits_iss;
  assign wb_hits_iss = bus.we && (bus.waddr == bus.iss_waddr);

  // A full counter blocks issue unless this cycle's write-back frees a slot
  // in the same register, which keeps the counter from ever wrapping.
  always_comb begin
    bus.iss_ready = 1'b1;
    if (!rst && (bus.iss_waddr != '0) &&
        (cnt[bus.iss_waddr] == CNT_MAX) && !wb_hits_iss)
      bus.iss_ready = 1'b0;
  end

  // Register 0 never gets an increment or a decrement, so cnt[0] stays zero.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r] = bus.iss_valid && bus.iss_ready && (r != 0) &&
                   (bus.iss_waddr == AW'(r));
      dec_vec[r] = bus.we && (r != 0) && (bus.waddr == AW'(r));
    end
  end

  // Read port 1: write-back bypass takes priority over storage.
  always_comb begin
    bus.rdata1 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      if (bus.we && (bus.waddr == bus.raddr1))
        bus.rdata1 = bus.wdata;
      else
        bus.rdata1 = regs[bus.raddr1];
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    bus.rdata2 = '0;
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      if (bus.we && (bus.waddr == bus.raddr2))
        bus.rdata2 = bus.wdata;
      else
        bus.rdata2 = regs[bus.raddr2];
    end
  end

  // A single outstanding write that lands this cycle is covered by the
  // bypass, so it is not a hazard; two or more outstanding still are.
  always_comb begin
    bus.hazard1 = 1'b0;
    if (!rst && bus.re1 && (bus.raddr1 != '0) && (cnt[bus.raddr1] != '0))
      bus.hazard1 = !((cnt[bus.raddr1] == CNT_ONE) && bus.we &&
                      (bus.waddr == bus.raddr1));
  end

  always_comb begin
    bus.hazard2 = 1'b0;
    if (!rst && bus.re2 && (bus.raddr2 != '0) && (cnt[bus.raddr2] != '0))
      bus.hazard2 = !((cnt[bus.raddr2] == CNT_ONE) && bus.we &&
                      (bus.waddr == bus.raddr2));
  end

  // Storage: a write-back lands even during a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
    end else if (bus.we && (bus.waddr != '0)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Scoreboard: issue and write-back to the same register cancel out;
  // a write-back to an idle register leaves it at zero.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end
endmodule
